// File: rtl/tx_sched_pkg.sv
// Shared constants and types for the transmit scheduler: default payload
// geometry, default inter-frame gap and the scheduler FSM state type.
package tx_sched_pkg;

  localparam int unsigned PAYLOAD_W   = 44;
  localparam int unsigned DIBITS      = PAYLOAD_W / 2;
  localparam int unsigned GAP_DEFAULT = 48;  // 96 bit times at 2 bits/cycle

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational. req[0]/gnt[0] is
// requester A, req[1]/gnt[1] is requester B. On a tie the requester that
// was not granted last wins; last_grant=1 means B was granted last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  // One-hot grant, zero whenever the scheduler cannot accept a payload.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Shares the 2-bit transmit datapath between two payload sources. One
// payload is granted per frame, sent MSB-first as PAYLOAD_W/2 dibits on
// axiov/axiod, then GAP idle cycles are enforced before the next grant.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = tx_sched_pkg::PAYLOAD_W,
  parameter int unsigned GAP       = tx_sched_pkg::GAP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [PAYLOAD_W-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [PAYLOAD_W-1:0] b_data,
  output logic                 b_ready,
  input  logic                 tx_ready,
  output logic                 axiov,
  output logic [1:0]           axiod,
  output logic                 tx_src,
  output logic                 tx_last,
  output logic [15:0]          sent_a,
  output logic [15:0]          sent_b
);

  localparam int unsigned DIB   = PAYLOAD_W / 2;
  localparam int unsigned CNT_W = (DIB > 1) ? $clog2(DIB) : 1;
  localparam int unsigned GAP_W = $clog2(GAP + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIB - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP);

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] shift_q;
  logic [CNT_W-1:0]     dibit_cnt_q;  // index of the dibit currently on axiod
  logic [GAP_W-1:0]     gap_cnt_q;    // gap cycles elapsed, 1-based
  logic                 last_grant_q; // 1: B granted last, so A wins the next tie

  logic [1:0]           gnt;
  logic                 arb_en;
  logic                 take;
  logic [PAYLOAD_W-1:0] payload;

  // Grants are only offered while idle, out of reset, with the transmitter free.
  assign arb_en  = (state_q == ST_IDLE) && tx_ready && !rst;
  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign take    = |gnt;
  assign payload = gnt[1] ? b_data : a_data;

  rr_arbiter2 u_arb (
    .req        ({b_valid, a_valid}),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .gnt        (gnt)
  );

  // Frame sequencing: idle until a grant, send all dibits, then hold the gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take) state_d = ST_SEND;
      ST_SEND: if (dibit_cnt_q == LAST_IDX) state_d = ST_GAP;
      ST_GAP:  if (gap_cnt_q == GAP_END) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Serializer: the first dibit goes out straight from the granted payload so
  // axiov rises the cycle after the handshake; the rest come from shift_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      dibit_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      axiov        <= 1'b0;
      axiod        <= 2'b00;
      tx_src       <= 1'b0;
      tx_last      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            shift_q      <= payload << 2;
            axiov        <= 1'b1;
            axiod        <= payload[PAYLOAD_W-1 -: 2];
            tx_src       <= gnt[1];
            tx_last      <= (DIB == 1);
            dibit_cnt_q  <= '0;
            last_grant_q <= gnt[1];
          end
        end
        ST_SEND: begin
          if (dibit_cnt_q == LAST_IDX) begin
            axiov     <= 1'b0;
            axiod     <= 2'b00;
            tx_last   <= 1'b0;
            gap_cnt_q <= GAP_W'(1);
          end else begin
            axiod       <= shift_q[PAYLOAD_W-1 -: 2];
            shift_q     <= shift_q << 2;
            dibit_cnt_q <= dibit_cnt_q + CNT_W'(1);
            tx_last     <= ((dibit_cnt_q + CNT_W'(1)) == LAST_IDX);
          end
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Accepted-frame counters, wrapping modulo 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_a <= 16'd0;
      sent_b <= 16'd0;
    end else begin
      if (gnt[0]) sent_a <= sent_a + 16'd1;
      if (gnt[1]) sent_b <= sent_b + 16'd1;
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: directed phases plus a randomized phase, all checked
// every cycle against a timeline model (frame start time, payload, and the
// earliest cycle a new grant may be offered), with literal pins on top.
module tb_tx_scheduler;

  localparam int PW   = 44;
  localparam int DIB  = PW / 2;
  localparam int GAPC = 48;
  localparam int PER  = DIB + GAPC + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0, tx_ready = 1'b0;
  logic [PW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, axiov, tx_src, tx_last;
  logic [1:0]    axiod;
  logic [15:0]   sent_a, sent_b;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int preload_seq = 0;

  tx_scheduler #(.PAYLOAD_W(PW), .GAP(GAPC)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .tx_ready (tx_ready),
    .axiov    (axiov),
    .axiod    (axiod),
    .tx_src   (tx_src),
    .tx_last  (tx_last),
    .sent_a   (sent_a),
    .sent_b   (sent_b)
  );

  always #5 clk = ~clk;

  // ---------------- model state (written only by the compare process)
  int            cyc = 0;
  int            free_at = 0;
  int            fr_t = -1000;
  int            nfr = 0;
  int            k;
  bit            armed = 1'b0, lg = 1'b1, fr_act = 1'b0, fr_src = 1'b0;
  bit            ev, ea, eb, idle;
  bit            lit_rst_done = 1'b0, p2_cnt_pending = 1'b0;
  logic [PW-1:0] fr_pay = '0;
  logic [15:0]   m_sa = 16'd0, m_sb = 16'd0;
  int            seen_preload = 0;
  int            hs_cyc[$];
  bit            hs_src[$];
  logic [3:0]    ord;
  logic [1:0]    lit_tab [DIB] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2,
                                   2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3,
                                   2'd1, 2'd0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: outputs are sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (preload_seq != seen_preload) begin
        seen_preload = preload_seq;
        m_sb = 16'hFFFF;
      end
      ea = 1'b0;
      eb = 1'b0;
      if (armed) begin
        k  = cyc - fr_t - 1;
        ev = fr_act && (k >= 0) && (k < DIB);
        chk("axiov", 64'(axiov), 64'(ev));
        chk("tx_last", 64'(tx_last), 64'(ev && (k == DIB - 1)));
        if (ev) begin
          chk("axiod", 64'(axiod), 64'(fr_pay[PW-1-2*k -: 2]));
          chk("tx_src", 64'(tx_src), 64'(fr_src));
        end
        chk("sent_a", 64'(sent_a), 64'(m_sa));
        chk("sent_b", 64'(sent_b), 64'(m_sb));
        idle = !rst && (cyc >= free_at);
        if (idle && tx_ready) begin
          if (a_valid && (!b_valid || lg)) ea = 1'b1;
          else if (b_valid)                eb = 1'b1;
        end
        chk("a_ready", 64'(a_ready), 64'(ea));
        chk("b_ready", 64'(b_ready), 64'(eb));

        // Literal pins.
        if (!lit_rst_done && rst) begin
          lit_rst_done = 1'b1;
          chk("rst_axiov", 64'(axiov), 64'd0);
          chk("rst_axiod", 64'(axiod), 64'd0);
          chk("rst_tx_src", 64'(tx_src), 64'd0);
          chk("rst_tx_last", 64'(tx_last), 64'd0);
          chk("rst_sent_a", 64'(sent_a), 64'd0);
          chk("rst_sent_b", 64'(sent_b), 64'd0);
          chk("rst_readies", 64'({a_ready, b_ready}), 64'd0);
        end
        if (phase == 1 && !rst) chk("first_idle_a_ready", 64'({a_ready, b_ready}), 64'b10);
        if (nfr == 1 && ev) begin
          chk("frame0_dibit", 64'(axiod), 64'(lit_tab[k]));
          if (k == 0) begin
            chk("frame0_src", 64'(tx_src), 64'd0);
            chk("frame0_sent_a", 64'(sent_a), 64'd1);
          end
          if (k == DIB - 1) chk("frame0_last", 64'(tx_last), 64'd1);
        end
        if (p2_cnt_pending) begin
          p2_cnt_pending = 1'b0;
          chk("rr_sent_a", 64'(sent_a), 64'd2);
          chk("rr_sent_b", 64'(sent_b), 64'd2);
        end
        if (phase == 3) begin
          chk("txoff_readies", 64'({a_ready, b_ready}), 64'd0);
          chk("txoff_axiov", 64'(axiov), 64'd0);
        end
        if (phase == 31) chk("txon_grant_a", 64'({a_ready, b_ready}), 64'b10);
        if (phase == 51) begin
          chk("midrst_axiov", 64'(axiov), 64'd0);
          chk("midrst_tx_last", 64'(tx_last), 64'd0);
          chk("midrst_counts", 64'({sent_a, sent_b}), 64'd0);
          chk("midrst_tie_a", 64'({a_ready, b_ready}), 64'b10);
        end
        if (phase == 61) chk("wrap_sent_b", 64'(sent_b), 64'd0);
      end

      // Model update at the clock edge that ends this cycle.
      if (rst) begin
        armed   = 1'b1;
        fr_act  = 1'b0;
        free_at = 0;
        lg      = 1'b1;
        m_sa    = 16'd0;
        m_sb    = 16'd0;
      end else if (ea || eb) begin
        fr_act  = 1'b1;
        fr_t    = cyc;
        fr_pay  = ea ? a_data : b_data;
        fr_src  = eb;
        free_at = cyc + DIB + GAPC + 1;
        lg      = eb;
        if (ea) m_sa = m_sa + 16'd1;
        else    m_sb = m_sb + 16'd1;
        nfr++;
        if (phase == 2) begin
          hs_cyc.push_back(cyc);
          hs_src.push_back(eb);
          if (hs_src.size() == 4) begin
            ord = {hs_src[0], hs_src[1], hs_src[2], hs_src[3]};
            chk("rr_order", 64'(ord), 64'b0101);
            for (int i = 1; i < 4; i++)
              chk("rr_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(PER));
            p2_cnt_pending = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus
  function automatic logic [PW-1:0] rnd_pay();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(output bit got_b);
    got_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_valid && a_ready) begin got_b = 1'b0; return; end
      if (b_valid && b_ready) begin got_b = 1'b1; return; end
    end
    $display("FAIL handshake_timeout: got no grant expected a grant within 200 cycles");
    $fatal(1, "handshake timeout");
  endtask

  initial begin
    bit gb, ha, hb;

    // Reset, then A alone with a known payload.
    rst = 1'b1;
    repeat (3) next_cyc();
    rst = 1'b0; a_valid = 1'b1; a_data = 44'hABC_DEF0_1234; tx_ready = 1'b1; phase = 1;
    wait_hs(gb);
    next_cyc(); a_valid = 1'b0; phase = 0;
    repeat (75) next_cyc();

    // Both requesters valid continuously from a fresh reset.
    rst = 1'b1;
    next_cyc();
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = rnd_pay(); b_data = rnd_pay();
    phase = 2;
    for (int i = 0; i < 4; i++) begin
      wait_hs(gb);
      next_cyc();
      if (i == 3) begin
        a_valid = 1'b0; b_valid = 1'b0; phase = 0;
      end else if (gb) b_data = rnd_pay();
      else             a_data = rnd_pay();
    end
    repeat (75) next_cyc();

    // Transmitter busy with both requesters pending, then released.
    phase = 3; tx_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_data = rnd_pay(); b_data = rnd_pay();
    repeat (10) next_cyc();
    phase = 31; tx_ready = 1'b1;
    wait_hs(gb);
    next_cyc(); phase = 0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (75) next_cyc();

    // Randomized valids, data and tx_ready, including toggling mid-frame.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      ha = a_valid && a_ready;
      hb = b_valid && b_ready;
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(0, 3) != 0);
      if (ha) begin
        a_valid = ($urandom_range(0, 1) == 1); a_data = rnd_pay();
      end else if (a_valid) begin
        if ($urandom_range(0, 7) == 0) a_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        a_valid = 1'b1; a_data = rnd_pay();
      end
      if (hb) begin
        b_valid = ($urandom_range(0, 1) == 1); b_data = rnd_pay();
      end else if (b_valid) begin
        if ($urandom_range(0, 7) == 0) b_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        b_valid = 1'b1; b_data = rnd_pay();
      end
    end
    next_cyc(); a_valid = 1'b0; b_valid = 1'b0; tx_ready = 1'b1;
    repeat (75) next_cyc();

    // Reset while the 10th dibit is on the wire.
    phase = 5; a_valid = 1'b1; b_valid = 1'b1; a_data = rnd_pay(); b_data = rnd_pay();
    wait_hs(gb);
    repeat (10) next_cyc();
    rst = 1'b1;
    next_cyc(); rst = 1'b0; phase = 51;
    next_cyc(); phase = 0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (75) next_cyc();

    // sent_b at 0xFFFF wraps to 0 on the next B grant.
    @(posedge clk); #2;
    force dut.sent_b = 16'hFFFF;
    preload_seq++;
    @(posedge clk); #2;
    release dut.sent_b;
    @(posedge clk); #1;
    b_valid = 1'b1; b_data = rnd_pay(); phase = 6;
    wait_hs(gb);
    next_cyc(); b_valid = 1'b0; phase = 61;
    next_cyc(); phase = 0;
    repeat (75) next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
